// File: rtl/fetch_controller.sv
// Instruction fetch front end: PC sequencing, one-deep memory pipeline, 2-entry output FIFO.
// Define FETCH_CONTROLLER_PERF_EN to add the fetch_count/stall_count performance counters.
module fetch_controller #(
    parameter int MEMORY_BITS = 8,
    parameter int MEMORY_SIZE = 256,
    parameter int RESET_PC    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [MEMORY_BITS-1:0] mem_pc,
    input  logic [MEMORY_BITS-1:0] mem_instruction,
    input  logic                   branch_valid,
    input  logic [MEMORY_BITS-1:0] branch_target,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MEMORY_BITS-1:0] out_instruction,
    output logic [MEMORY_BITS-1:0] out_pc
`ifdef FETCH_CONTROLLER_PERF_EN
    ,
    output logic [15:0]            fetch_count,
    output logic [15:0]            stall_count
`endif
);

    localparam int W  = MEMORY_BITS;
    localparam int XW = (W > 32) ? W : 32;
    localparam logic [W-1:0] LAST_PC = W'(MEMORY_SIZE - 1);
    localparam logic [W-1:0] RST_PC  = W'(RESET_PC);

    logic [W-1:0]  r_fetch_pc;
    logic          r_inflight;
    logic [W-1:0]  r_inflight_pc;
    logic [1:0]    r_count;
    logic [W-1:0]  r_pc0;
    logic [W-1:0]  r_ins0;
    logic [W-1:0]  r_pc1;
    logic [W-1:0]  r_ins1;

    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic          w_slot1;
    logic [2:0]    w_occ;
    logic [W-1:0]  w_next_pc;
    logic [XW-1:0] w_tgt_ext;
    logic [W-1:0]  w_target;

    assign mem_pc          = r_fetch_pc;
    assign out_valid       = (r_count != 2'd0);
    assign out_pc          = r_pc0;
    assign out_instruction = r_ins0;

    // Handshake, occupancy and address arithmetic
    always_comb begin
        w_pop     = out_valid && out_ready;
        w_push    = r_inflight && ((r_count != 2'd2) || w_pop);
        w_occ     = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
        w_issue   = !rst && !branch_valid && (w_occ < 3'd2);
        w_slot1   = (r_count == 2'd2) || ((r_count == 2'd1) && !w_pop);
        w_next_pc = (r_fetch_pc == LAST_PC) ? '0 : r_fetch_pc + W'(1);
        w_tgt_ext = XW'(branch_target);
        w_target  = W'(w_tgt_ext % XW'(MEMORY_SIZE));
    end

    // Fetch PC, in-flight tracking and shift-style output FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RST_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_count       <= 2'd0;
            r_pc0         <= '0;
            r_ins0        <= '0;
            r_pc1         <= '0;
            r_ins1        <= '0;
        end else if (branch_valid) begin
            r_fetch_pc <= w_target;
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
                r_fetch_pc    <= w_next_pc;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop) begin
                r_pc0  <= r_pc1;
                r_ins0 <= r_ins1;
            end
            if (w_push) begin
                if (w_slot1) begin
                    r_pc1  <= r_inflight_pc;
                    r_ins1 <= mem_instruction;
                end else begin
                    r_pc0  <= r_inflight_pc;
                    r_ins0 <= mem_instruction;
                end
            end
        end
    end

`ifdef FETCH_CONTROLLER_PERF_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_stall_cnt;

    assign fetch_count = r_fetch_cnt;
    assign stall_count = r_stall_cnt;

    // Saturating transfer and back-pressure counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= 16'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            if (w_pop && (r_fetch_cnt != 16'hFFFF))
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: cycle table plus scoreboarded sequences.
// A second instance with MEMORY_SIZE=16 covers PC wrap and target reduction.
module tb_fetch_controller;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [7:0] mem_pc;
    logic [7:0] mem_instr;
    logic       br_v = 1'b0;
    logic [7:0] br_t = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_instr;
    logic [7:0] out_pc;

    logic       rst16 = 1'b1;
    logic [7:0] mem_pc16;
    logic [7:0] mem_instr16;
    logic       br16 = 1'b0;
    logic [7:0] tgt16 = 8'h00;
    logic       out_valid16;
    logic       out_ready16 = 1'b0;
    logic [7:0] out_instr16;
    logic [7:0] out_pc16;

`ifdef FETCH_CONTROLLER_PERF_EN
    logic [15:0] fc;
    logic [15:0] sc;
    logic [15:0] fc16;
    logic [15:0] sc16;
`endif

    fetch_controller dut (
        .clk(clk),
        .rst(rst),
        .mem_pc(mem_pc),
        .mem_instruction(mem_instr),
        .branch_valid(br_v),
        .branch_target(br_t),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instruction(out_instr),
        .out_pc(out_pc)
`ifdef FETCH_CONTROLLER_PERF_EN
        ,
        .fetch_count(fc),
        .stall_count(sc)
`endif
    );

    fetch_controller #(
        .MEMORY_BITS(8),
        .MEMORY_SIZE(16),
        .RESET_PC(0)
    ) dut16 (
        .clk(clk),
        .rst(rst16),
        .mem_pc(mem_pc16),
        .mem_instruction(mem_instr16),
        .branch_valid(br16),
        .branch_target(tgt16),
        .out_valid(out_valid16),
        .out_ready(out_ready16),
        .out_instruction(out_instr16),
        .out_pc(out_pc16)
`ifdef FETCH_CONTROLLER_PERF_EN
        ,
        .fetch_count(fc16),
        .stall_count(sc16)
`endif
    );

    function automatic logic [7:0] rom(input logic [7:0] a);
        return a + 8'h10;
    endfunction

    // Synchronous instruction ROM: data valid the cycle after the address
    always @(posedge clk) begin
        mem_instr   <= rom(mem_pc);
        mem_instr16 <= rom(mem_pc16);
    end

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] pc;
        logic [7:0] ins;
    } exp_t;

    exp_t q[$];
    exp_t q16[$];
    bit   sb_en   = 1'b0;
    bit   sb16_en = 1'b0;

    function automatic void expect_pc(input bit use16, input logic [7:0] pc);
        exp_t e;
        e.pc  = pc;
        e.ins = rom(pc);
        if (use16) q16.push_back(e);
        else q.push_back(e);
    endfunction

    // Scoreboard monitor for the default instance
    always @(negedge clk) begin
        exp_t e;
        if (sb_en && out_valid === 1'b1 && out_ready) begin
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb extra transfer: got pc %0h, expected none", out_pc);
            end else begin
                e = q.pop_front();
                chk("sb out_pc", out_pc, e.pc);
                chk("sb out_instruction", out_instr, e.ins);
            end
        end
    end

    // Scoreboard monitor for the 16-word instance
    always @(negedge clk) begin
        exp_t e;
        if (sb16_en && out_valid16 === 1'b1 && out_ready16) begin
            if (q16.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb16 extra transfer: got pc %0h, expected none", out_pc16);
            end else begin
                e = q16.pop_front();
                chk("sb16 out_pc", out_pc16, e.pc);
                chk("sb16 out_instruction", out_instr16, e.ins);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input bit use16, input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            step();
            done = use16 ? (q16.size() == 0) : (q.size() == 0);
        end
        if (use16) out_ready16 = 1'b0;
        else out_ready = 1'b0;
        chk(name, {31'd0, done}, 32'd1);
    endtask

    task automatic reset_dut();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    typedef struct {
        bit         rst;
        bit         rdy;
        bit         chk;
        bit         v;
        logic [7:0] opc;
        logic [7:0] oins;
        logic [7:0] mpc;
    } vec_t;

    vec_t tbl[19];

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{1, 0, 1, 0, 8'h00, 8'h00, 8'h00};
        tbl[2]  = '{0, 0, 1, 0, 8'h00, 8'h00, 8'h00};
        tbl[3]  = '{0, 0, 1, 0, 8'h00, 8'h00, 8'h01};
        tbl[4]  = '{0, 0, 1, 1, 8'h00, 8'h10, 8'h02};
        tbl[5]  = '{0, 0, 1, 1, 8'h00, 8'h10, 8'h02};
        tbl[6]  = '{0, 0, 1, 1, 8'h00, 8'h10, 8'h02};
        tbl[7]  = '{0, 0, 1, 1, 8'h00, 8'h10, 8'h02};
        tbl[8]  = '{0, 0, 1, 1, 8'h00, 8'h10, 8'h02};
        tbl[9]  = '{0, 1, 1, 1, 8'h00, 8'h10, 8'h02};
        tbl[10] = '{0, 1, 1, 1, 8'h01, 8'h11, 8'h03};
        tbl[11] = '{0, 1, 1, 1, 8'h02, 8'h12, 8'h04};
        tbl[12] = '{0, 1, 1, 1, 8'h03, 8'h13, 8'h05};
        tbl[13] = '{0, 0, 1, 1, 8'h04, 8'h14, 8'h06};
        tbl[14] = '{1, 0, 1, 1, 8'h04, 8'h14, 8'h06};
        tbl[15] = '{0, 1, 1, 0, 8'h00, 8'h00, 8'h00};
        tbl[16] = '{0, 1, 1, 0, 8'h00, 8'h00, 8'h01};
        tbl[17] = '{0, 1, 1, 1, 8'h00, 8'h10, 8'h02};
        tbl[18] = '{0, 1, 1, 1, 8'h01, 8'h11, 8'h03};

        // Reset, latency, stall stability, release and mid-run reset
        for (int i = 0; i < 19; i++) begin
            step();
            rst       = tbl[i].rst;
            out_ready = tbl[i].rdy;
            @(negedge clk);
            if (tbl[i].chk) begin
                chk($sformatf("tbl[%0d] out_valid", i), {31'd0, out_valid}, {31'd0, tbl[i].v});
                chk($sformatf("tbl[%0d] out_pc", i), out_pc, tbl[i].opc);
                chk($sformatf("tbl[%0d] out_instruction", i), out_instr, tbl[i].oins);
                chk($sformatf("tbl[%0d] mem_pc", i), mem_pc, tbl[i].mpc);
            end
        end

        // Streaming with a 3-cycle stall: 10 transfers in order
        out_ready = 1'b0;
        sb_en     = 1'b1;
        reset_dut();
        for (int p = 0; p < 10; p++) expect_pc(1'b0, 8'(p));
        out_ready = 1'b1;
        repeat (7) step();
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1;
        repeat (5) step();
        out_ready = 1'b0;
        @(negedge clk);
        chk("stream queue empty", q.size(), 0);
        chk("stream head out_valid", {31'd0, out_valid}, 32'd1);
        chk("stream head out_pc", out_pc, 8'h0a);
`ifdef FETCH_CONTROLLER_PERF_EN
        chk("perf fetch_count", fc, 16'd10);
        chk("perf stall_count", sc, 16'd3);
`endif

        // Branch to 0x40 while FIFO full, head popped in the same cycle
        reset_dut();
        repeat (3) step();
        @(negedge clk);
        chk("pre-branch out_valid", {31'd0, out_valid}, 32'd1);
        chk("pre-branch out_pc", out_pc, 8'h00);
        chk("pre-branch mem_pc", mem_pc, 8'h02);
        expect_pc(1'b0, 8'h00);
        for (int p = 0; p < 6; p++) expect_pc(1'b0, 8'(8'h40 + p));
        br_v      = 1'b1;
        br_t      = 8'h40;
        out_ready = 1'b1;
        step();
        br_v = 1'b0;
        @(negedge clk);
        chk("branch b+1 out_valid", {31'd0, out_valid}, 32'd0);
        chk("branch b+1 mem_pc", mem_pc, 8'h40);
        step();
        @(negedge clk);
        chk("branch b+2 out_valid", {31'd0, out_valid}, 32'd0);
        chk("branch b+2 mem_pc", mem_pc, 8'h41);
        step();
        @(negedge clk);
        chk("branch b+3 out_valid", {31'd0, out_valid}, 32'd1);
        chk("branch b+3 out_pc", out_pc, 8'h40);
        drain(1'b0, "branch drain");
        sb_en = 1'b0;

        // 16-word instance: reset beats branch, wrap 14->15->0, target reduction
        br16  = 1'b1;
        tgt16 = 8'h05;
        step();
        @(negedge clk);
        chk("rst over branch mem_pc", mem_pc16, 8'h00);
        chk("rst over branch out_valid", {31'd0, out_valid16}, 32'd0);
        rst16       = 1'b0;
        tgt16       = 8'd14;
        out_ready16 = 1'b1;
        sb16_en     = 1'b1;
        expect_pc(1'b1, 8'd14);
        expect_pc(1'b1, 8'd15);
        expect_pc(1'b1, 8'd0);
        expect_pc(1'b1, 8'd1);
        expect_pc(1'b1, 8'd2);
        step();
        br16 = 1'b0;
        @(negedge clk);
        chk("wrap b+1 mem_pc", mem_pc16, 8'd14);
        drain(1'b1, "wrap drain");
        br16  = 1'b1;
        tgt16 = 8'h23;
        step();
        br16 = 1'b0;
        @(negedge clk);
        chk("target modulo mem_pc", mem_pc16, 8'd3);
        expect_pc(1'b1, 8'd3);
        expect_pc(1'b1, 8'd4);
        out_ready16 = 1'b1;
        drain(1'b1, "modulo drain");
        sb16_en = 1'b0;

        chk("final queue", q.size(), 0);
        chk("final queue16", q16.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
